// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage; serializes loads/stores over a byte-wide RAM port
// while holding the pipeline via stall_req, and passes ALU results through otherwise.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [31:0]       ex_rd_data,
  input  logic [4:0]        ex_rd_addr,
  input  logic              ex_rd_enable,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_mem_op,
  input  logic [31:0]       ex_mem_wdata,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  output logic [31:0]       mem_rd_data,
  output logic [4:0]        mem_rd_addr,
  output logic              mem_rd_enable,
  output logic              stall_req
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d, n, idx, ci;
  logic [31:0]       buf_q, buf_d, ld_data;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              iss_q, iss_d, issue, is_st, is_ld, mem_op;
  assign is_st  = ex_mem_write;
  assign is_ld  = ex_mem_read & ~ex_mem_write;
  assign mem_op = is_st | is_ld;
  assign n      = ex_mem_op[1] ? 3'd4 : ex_mem_op[0] ? 3'd2 : 3'd1;
  assign ci     = cnt_q - 3'd1;
  // iss_q marks a read issued on the previous rdy-high cycle; a rdy-low cycle drops it,
  // forcing the same byte (cnt_q-1) to be re-issued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    iss_d   = 1'b0;
    issue   = 1'b0;
    idx     = cnt_q;
    if (rdy) begin
      if (state_q == IDLE) begin
        if (mem_op) begin
          issue   = 1'b1;
          idx     = 3'd0;
          cnt_d   = 3'd1;
          iss_d   = is_ld;
          state_d = (is_st && n == 3'd1) ? DONE : ACCESS;
        end
      end else if (state_q == ACCESS) begin
        if (is_st) begin
          issue   = 1'b1;
          cnt_d   = cnt_q + 3'd1;
          state_d = (cnt_q + 3'd1 == n) ? DONE : ACCESS;
        end else if (iss_q) begin
          buf_d[{ci[1:0], 3'b000} +: 8] = ram_din;
          if (cnt_q < n) begin
            issue = 1'b1;
            cnt_d = cnt_q + 3'd1;
            iss_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          issue = 1'b1;
          idx   = ci;
          iss_d = 1'b1;
        end
      end else begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    end
  end
  assign addr_d  = issue ? ADDR_W'(ex_rd_data) + ADDR_W'(idx) : addr_q;
  assign ld_data = ex_mem_op == 3'b000 ? {{24{buf_q[7]}}, buf_q[7:0]} :
                   ex_mem_op == 3'b001 ? {{16{buf_q[15]}}, buf_q[15:0]} :
                   ex_mem_op == 3'b100 ? {24'b0, buf_q[7:0]} :
                   ex_mem_op == 3'b101 ? {16'b0, buf_q[15:0]} : buf_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      buf_q   <= 32'd0;
      addr_q  <= '0;
      iss_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      iss_q   <= iss_d;
    end
  end
  assign ram_addr      = rst ? addr_d : '0;
  assign ram_dout      = rst ? ex_mem_wdata[{idx[1:0], 3'b000} +: 8] : 8'd0;
  assign ram_wr        = rst & issue & is_st;
  assign stall_req     = rst & ((state_q == IDLE & mem_op) | state_q == ACCESS);
  assign mem_rd_data   = !rst ? 32'd0 : (state_q == DONE && is_ld) ? ld_data : ex_rd_data;
  assign mem_rd_addr   = rst ? ex_rd_addr : 5'd0;
  assign mem_rd_enable = rst & ex_rd_enable &
                         (state_q == IDLE ? ~mem_op : state_q == DONE ? ~is_st : 1'b0);
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a byte-array
// memory model and an access-level expectation of results, writes and latency.
module tb_mem_stage;
  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1;
  logic [31:0] ex_rd_data = 32'h0, ex_mem_wdata = 32'h0;
  logic [4:0]  ex_rd_addr = 5'd0;
  logic        ex_rd_enable = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic [2:0]  ex_mem_op = 3'd0;
  logic [7:0]  ram_din = 8'd0, ram_dout;
  logic [31:0] ram_addr, mem_rd_data;
  logic        ram_wr, mem_rd_enable, stall_req;
  logic [4:0]  mem_rd_addr;
  bit   [7:0]  ram [1024];
  bit   [7:0]  ref_mem [1024];
  int          n_chk = 0, n_err = 0;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ex_rd_data(ex_rd_data), .ex_rd_addr(ex_rd_addr), .ex_rd_enable(ex_rd_enable),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_op(ex_mem_op),
    .ex_mem_wdata(ex_mem_wdata), .ram_din(ram_din), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .ram_wr(ram_wr), .mem_rd_data(mem_rd_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr[9:0]] <= ram_dout;
    ram_din <= ram[ram_addr[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mode 0: rdy always high; 1: random rdy; 2: rdy low in cycles 2 and 3
  task automatic run_op(input logic st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input int mode,
                        input int exp_cyc);
    int n, k, wrs, cyc;
    logic [31:0] w, exp;
    logic seen;
    n = op[1] ? 4 : op[0] ? 2 : 1;
    w = 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[(a + i) & 1023];
    case (op)
      3'b000:  exp = {{24{w[7]}}, w[7:0]};
      3'b001:  exp = {{16{w[15]}}, w[15:0]};
      3'b100:  exp = {24'b0, w[7:0]};
      3'b101:  exp = {16'b0, w[15:0]};
      default: exp = w;
    endcase
    if (st) for (int i = 0; i < n; i++) ref_mem[(a + i) & 1023] = wd[8*i +: 8];
    @(posedge clk); #1;
    ex_rd_data = a; ex_rd_addr = rd; ex_rd_enable = 1'b1; ex_mem_op = op;
    ex_mem_wdata = wd; ex_mem_write = st; ex_mem_read = ~st;
    wrs = 0; seen = 1'b0;
    for (k = 0; k < 60; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      rdy = mode == 0 ? 1'b1 : mode == 2 ? !(k == 2 || k == 3) : ($urandom_range(0, 3) != 0);
      #4;
      if (!rdy) check("wr_gated", ram_wr, 1'b0);
      if (ram_wr) wrs++;
      if (mode == 0 && k < n) begin
        check("addr", ram_addr, a + k);
        check("wr_strobe", ram_wr, st);
        if (st) check("wdata", ram_dout, wd[8*k +: 8]);
      end
      if (!stall_req) begin
        if (!seen) begin
          if (!st) check("ld_data", mem_rd_data, exp);
          check("wb_en", mem_rd_enable, !st);
          check("wb_rd", mem_rd_addr, rd);
        end
        seen = 1'b1;
        if (rdy) break;
      end
    end
    if (k == 60) check("timeout", 32'd1, 32'd0);
    cyc = mode == 0 ? (st ? n + 1 : n + 2) : exp_cyc;
    if (cyc > 0) check("latency", k + 1, cyc);
    if (st) check("wr_count", wrs, n);
    @(posedge clk); #1;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; rdy = 1'b1;
  endtask

  task automatic pass_through(input logic [31:0] d, input logic [4:0] rd, input logic en);
    @(posedge clk); #1;
    ex_rd_data = d; ex_rd_addr = rd; ex_rd_enable = en;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; rdy = 1'b1;
    #1;
    check("pt_data", mem_rd_data, d);
    check("pt_rd", mem_rd_addr, rd);
    check("pt_en", mem_rd_enable, en);
    check("pt_stall", stall_req, 1'b0);
  endtask

  initial begin
    logic [2:0] ops [5];
    int kind;
    logic [31:0] bad;
    ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    ex_rd_data = 32'hDEADBEEF; ex_rd_enable = 1'b1; ex_mem_read = 1'b1;
    #2;
    check("rst_data", mem_rd_data, 32'h0);
    check("rst_addr", ram_addr, 32'h0);
    check("rst_stall", stall_req, 1'b0);
    check("rst_wr", ram_wr, 1'b0);
    ex_mem_read = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    pass_through(32'h12345678, 5'd5, 1'b1);
    run_op(1'b1, 3'b010, 32'h100, 32'h12345678, 5'd0, 0, 0);
    run_op(1'b1, 3'b000, 32'h7, 32'h00000080, 5'd0, 0, 0);
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd9, 0, 0);
    run_op(1'b0, 3'b000, 32'h7, 32'h0, 5'd3, 0, 0);
    run_op(1'b0, 3'b100, 32'h7, 32'h0, 5'd4, 0, 0);
    run_op(1'b1, 3'b001, 32'h201, 32'hAABBCCDD, 5'd0, 0, 0);
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd7, 2, 9);
    // store interrupted by reset after its second byte lands
    @(posedge clk); #1;
    ex_rd_data = 32'h300; ex_mem_op = 3'b010; ex_mem_wdata = 32'hCAFEBABE;
    ex_mem_write = 1'b1; ex_rd_enable = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_wr", ram_wr, 1'b0);
    check("mid_rst_addr", ram_addr, 32'h0);
    check("mid_rst_stall", stall_req, 1'b0);
    check("mid_rst_en", mem_rd_enable, 1'b0);
    check("mid_rst_data", mem_rd_data, 32'h0);
    ref_mem[10'h300] = 8'hBE; ref_mem[10'h301] = 8'hBA;
    ex_mem_write = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #4;
    check("post_rst_stall", stall_req, 1'b0);
    run_op(1'b0, 3'b010, 32'h300, 32'h0, 5'd2, 0, 0);
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) pass_through($urandom, 5'($urandom), 1'($urandom));
      else run_op(kind == 2, kind == 2 ? ops[$urandom_range(0, 2)] : ops[$urandom_range(0, 4)],
                  32'($urandom_range(0, 1019)), $urandom, 5'($urandom),
                  $urandom_range(0, 1), 0);
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] != ref_mem[i]) bad++;
    check("ram_image", bad, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV32I pipeline: sits between ex_mem and mem_wb, passing ALU results through and executing loads and stores over the shared byte-wide RAM port. A multi-byte access is serialized over several cycles, with the pipeline held via a stall request. Its result outputs feed the mem_wb register directly.

## Interface
- ADDR_W, 32, RAM/byte address width
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- rdy  input  1  global ready; low freezes all state
- ex_rd_data  input  32  ALU result, or load/store effective address
- ex_rd_addr  input  5  destination register
- ex_rd_enable  input  1  register write enable
- ex_mem_read  input  1  instruction is a load
- ex_mem_write  input  1  instruction is a store
- ex_mem_op  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_mem_wdata  input  32  store data (rs2)
- ram_din  input  8  RAM read byte, valid the cycle after the address is issued
- ram_addr  output  ADDR_W  RAM byte address
- ram_dout  output  8  RAM write byte
- ram_wr  output  1  RAM write strobe (1 = write, 0 = read)
- mem_rd_data  output  32  result to mem_wb
- mem_rd_addr  output  5  destination register to mem_wb
- mem_rd_enable  output  1  write enable to mem_wb
- stall_req  output  1  hold IF..EX/MEM; stall controller drives stall[2] from it

## Operation
- Byte count N: 1 for B/BU, 2 for H/HU, 4 for W. No alignment is required; byte k is at ex_rd_data+k (little-endian).
- FSM states: IDLE, ACCESS, DONE. Byte index cnt is 3 bits.
- IDLE, no memory op: outputs pass through combinationally (mem_rd_data=ex_rd_data etc.); stall_req=0.
- IDLE with a load or store:
  - stall_req=1.
  - Issue byte 0 (ram_addr=ex_rd_data, ram_wr=ex_mem_write, ram_dout=wdata[7:0]).
  - Set cnt=1 and go to ACCESS.
- ACCESS:
  - stall_req=1.
  - While cnt<N: issue byte cnt, then cnt+1.
  - Load: ram_din is captured into buffer byte (issued index) one cycle after each issue.
  - Go to DONE once all N bytes are written (store) or captured (load).
  - Between issues, ram_wr=0 and ram_addr holds the last issued address.
- DONE:
  - stall_req=0.
  - mem_rd_data is the assembled word: LB/LH sign-extended, LBU/LHU zero-extended, W unmodified.
  - Store: mem_rd_enable=0.
  - Always go to IDLE on the next edge. The pipeline advances on that edge, so the same instruction is never re-executed.
- ex_mem_read and ex_mem_write are never both set. If they are, the store takes precedence.
- rdy low:
  - FSM, cnt and buffer are held; ram_wr is forced 0.
  - A read whose data-return cycle falls in a rdy-low cycle is discarded. That byte is re-issued on the next rdy-high cycle (tracked with a registered issued-read flag).
- rst low: immediately go to IDLE with cnt=0 and the buffer cleared. All outputs are 0 while reset is held (ram_addr=0, ram_wr=0, stall_req=0, mem_rd_*=0).

## Timing
- Non-memory instruction: 0 added cycles.
- Load: issues occur in cycles 0..N-1 and the last capture is in cycle N. DONE is in cycle N+1, so the instruction occupies N+2 cycles (LB 3, LH 4, LW 6).
- Store: issues occur in cycles 0..N-1 and DONE is in cycle N, so the instruction occupies N+1 cycles (SB 2, SW 5).
- stall_req rises combinationally in the cycle the memory op appears in IDLE. It falls in DONE.
- mem_wb samples the result at the DONE→IDLE edge.
- Reset asserted mid-access abandons the access: no further writes, and no partial result is forwarded.

## Test plan
- ALU pass-through: ex_rd_data=0x12345678, rd=5, enable=1, no mem op -> the same values appear on mem_rd_* in the same cycle; stall_req=0.
- LW at 0x100, RAM[0x100..0x103]=78 56 34 12 -> stall_req high for 5 cycles; ram_addr sequence 0x100..0x103; DONE presents 0x12345678 with rd enabled.
- LB/LBU at 0x7, RAM[0x7]=0x80 -> LB yields 0xFFFFFF80 and LBU yields 0x00000080; each takes 3 cycles.
- SH of 0xAABBCCDD at 0x201 (unaligned) -> writes 0xDD to 0x201 and 0xCC to 0x202 with ram_wr=1 on exactly 2 cycles; DONE has mem_rd_enable=0.
- LW with rdy pulled low for 2 cycles after byte 1 is issued -> byte 1 is re-issued after rdy returns; the final word is still correct and the latency grows by 2 plus the re-issue.
- SW with rst low after byte 1 -> outputs are 0 immediately and only bytes 0 and 1 are written; after reset is released, the FSM is in IDLE with stall_req=0.
